packed_dual_col_mac_acc: RTL
============================

# packed_dual_col_mac_acc

Two-column multiply-accumulate for the CONV MAC array. One DSP multiply per beat serves two weight columns: wt1 is packed above wt0 in a single wide operand and multiplied by one shared activation. Beats are accumulated over an input-channel run marked by first/last flags, with a valid/ready handshake. The block sits between the CONV operand fetch (activation + weight-pair stream) and the partial-sum collector, and replaces the non-accumulating, handshake-free two-column DSP MAC.

## Interface
Parameters:
- DAT_DW, 8, activation width (signed)
- WT_DW, 8, weight width per column (signed)
- ACC_DW, 32, accumulator/output width per column
- PACK_SHIFT, 19, bit offset of wt1 inside the packed DSP operand; 17 for 25-bit pre-adder devices, 19 for 27-bit

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_vld  in  1  input beat valid
- in_rdy  out  1  block accepts beat this cycle
- in_first  in  1  beat starts a new accumulation run
- in_last  in  1  beat ends the run
- dat  in  DAT_DW  shared activation
- wt0  in  WT_DW  column-0 weight
- wt1  in  WT_DW  column-1 weight
- mode  in  1  0 = INT8, 1 = INT4 dual-lane (ignored unless MAC_INT4_EN)
- out_vld  out  1  accumulated pair valid
- out_rdy  in  1  downstream accepts result
- acc0  out  ACC_DW  column-0 sum
- acc1  out  ACC_DW  column-1 sum

## Operation
- Global advance enable: en = !out_vld | out_rdy; in_rdy = en. Beat accepted when in_vld & in_rdy.
- Stages, each advancing only when en = 1; per-stage valid bit carries first/last:
  - S0: register dat, wt0, wt1, mode, first, last.
  - S1: P = ((wt1 << PACK_SHIFT) + sext(wt0)) * sext(dat), signed, mapped to DSP.
  - S2: lo = P[15:0]; hi = P[PACK_SHIFT+15:PACK_SHIFT] + lo[15] (borrow correction); both signed 16-bit.
  - S3: accumulate. first: acc = sext(lo/hi); else acc += sext(lo/hi). Wrap-around two's complement, no saturation.
- out_vld sets when a last beat completes S3; clears on out_vld & out_rdy unless another last beat completes in the same cycle.
- first & last on one beat: single-beat result.
- Beat without a preceding first: added to current acc (no error flag).
- Bubbles (S-valid = 0) leave acc unchanged.
- Products are exact for all operands, including -128 * -128 = 16384.

## Timing
- Reset: in_rdy = 1 after reset (out_vld = 0); out_vld = 0; acc0 = acc1 = 0; all stage valids 0.
- Latency: last beat accepted at cycle T -> out_vld = 1 at T+4.
- Throughput: one beat per cycle while out_rdy = 1 or out_vld = 0.
- Stall: out_vld & !out_rdy freezes every stage and deasserts in_rdy; acc0/acc1 stay stable until handshake.
- Simultaneous out handshake and new last completing S3: out_vld stays 1 and acc updates; no gap.
- rst_n low mid-run: immediate clear of all state; partial run discarded.

## Configuration
- MAC_INT4_EN defined: mode = 1 treats dat, wt0, wt1 as two signed 4-bit lanes; colN = dat[3:0]*wtN[3:0] + dat[7:4]*wtN[7:4], computed in fabric LUTs in S1, registered through S2 with the same latency. The DSP path is bypassed for that beat.
- Undefined: mode is ignored; INT8 path only; no LUT multipliers synthesised.

## Structure
- Shared CNN defines package: DAT_DW/WT_DW/ACC_DW defaults, PACK_SHIFT per device family, product width constant (16).
- Sub-module packed_dsp_mul: S1 multiply plus S2 unpack/correct; isolates the DSP inference attribute and device-specific shift.

## Test plan
- INT8 single beat, first = last = 1, dat = -128, wt0 = -128, wt1 = 127 -> at T+4: acc0 = 16384, acc1 = -16256.
- Borrow check: dat = 3, wt0 = -5, wt1 = 7 -> acc0 = -15, acc1 = 21 (hi corrected by lo sign).
- Run of 4 beats: dat = 10, wt0 = 1, wt1 = -2, first on beat 0, last on beat 3 -> one result: acc0 = 40, acc1 = -80; out_vld is 1 exactly once.
- Backpressure: out_rdy = 0 for 5 cycles while a result is pending -> in_rdy = 0, acc stable; the result is released on out_rdy = 1, and the next run is intact.
- Reset mid-run after 2 beats -> outputs 0 immediately; a fresh first/last run then yields the correct values.
- MAC_INT4_EN, mode = 1: dat = 0x7F, wt0 = 0x2F -> acc0 = (-1)(-1) + 7*2 = 15.

Source files
------------

// File: rtl/packed_dual_col_mac_acc_pkg.sv
// Shared CNN MAC defines: default widths, per-device pack shift, product width
// and the INT4 lane dot-product helper (only used when MAC_INT4_EN is defined).
package packed_dual_col_mac_acc_pkg;

   localparam int DAT_DW_DEF     = 8;
   localparam int WT_DW_DEF      = 8;
   localparam int ACC_DW_DEF     = 32;

   // wt1 sits this far above wt0 in the packed DSP operand
   localparam int PACK_SHIFT_25B = 17;   // 25-bit pre-adder devices
   localparam int PACK_SHIFT_27B = 19;   // 27-bit pre-adder devices
   localparam int PACK_SHIFT_DEF = PACK_SHIFT_27B;

   // width of one unpacked column product (8x8 signed)
   localparam int PROD_W         = 16;

   // first/last markers travelling alongside each stage valid bit
   typedef struct packed {
      logic first;
      logic last;
   } beat_tag_t;

   // two signed 4-bit lanes: a[3:0]*b[3:0] + a[7:4]*b[7:4]
   function automatic logic signed [PROD_W-1:0] int4_dot(input logic [7:0] a,
                                                         input logic [7:0] b);
      logic signed [PROD_W-1:0] p_lo;
      logic signed [PROD_W-1:0] p_hi;
      p_lo = PROD_W'($signed(a[3:0])) * PROD_W'($signed(b[3:0]));
      p_hi = PROD_W'($signed(a[7:4])) * PROD_W'($signed(b[7:4]));
      return p_lo + p_hi;
   endfunction

endpackage

// File: rtl/packed_dual_col_mac_acc_packed_dsp_mul.sv
// packed_dsp_mul: S1 packed multiply ((wt1<<PACK_SHIFT)+wt0)*dat in one DSP,
// S2 unpack into two signed 16-bit column products with borrow correction.
// With MAC_INT4_EN defined, mode=1 beats use LUT-based INT4 dot products
// instead, carried through S2 with identical latency.
module packed_dsp_mul
   import packed_dual_col_mac_acc_pkg::*;
#(
   parameter int DAT_DW     = DAT_DW_DEF,
   parameter int WT_DW      = WT_DW_DEF,
   parameter int PACK_SHIFT = PACK_SHIFT_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [DAT_DW-1:0]        s0_dat,
   input  logic [WT_DW-1:0]         s0_wt0,
   input  logic [WT_DW-1:0]         s0_wt1,
   input  logic                     s0_mode,
   output logic signed [PROD_W-1:0] s2_lo,
   output logic signed [PROD_W-1:0] s2_hi
);

   // packed operand needs one guard bit: 127<<19 plus negative wt0 must not wrap
   localparam int A_W = PACK_SHIFT + WT_DW + 1;
   localparam int P_W = A_W + DAT_DW;

   logic signed [P_W-1:0] op_a;
   logic signed [P_W-1:0] op_b;
   logic signed [P_W-1:0] p_d;
   (* use_dsp = "yes" *) logic signed [P_W-1:0] p_q;
   logic signed [PROD_W-1:0] lo_d, lo_q;
   logic signed [PROD_W-1:0] hi_d, hi_q;

   // S1 operand packing and the single shared multiply
   always_comb begin
      op_a = ($signed({{(P_W-WT_DW){s0_wt1[WT_DW-1]}}, s0_wt1}) <<< PACK_SHIFT)
           + $signed({{(P_W-WT_DW){s0_wt0[WT_DW-1]}}, s0_wt0});
      op_b = $signed({{(P_W-DAT_DW){s0_dat[DAT_DW-1]}}, s0_dat});
      p_d  = op_a * op_b;
   end

`ifdef MAC_INT4_EN
   logic signed [PROD_W-1:0] i4_0_d, i4_0_q;
   logic signed [PROD_W-1:0] i4_1_d, i4_1_q;
   logic                     mode_q;

   // S1 LUT INT4 dual-lane products for both columns
   always_comb begin
      i4_0_d = int4_dot(s0_dat[7:0], s0_wt0[7:0]);
      i4_1_d = int4_dot(s0_dat[7:0], s0_wt1[7:0]);
   end

   // S1 INT4 result registers, frozen while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i4_0_q <= '0;
         i4_1_q <= '0;
         mode_q <= 1'b0;
      end else if (en) begin
         i4_0_q <= i4_0_d;
         i4_1_q <= i4_1_d;
         mode_q <= s0_mode;
      end
   end
`else
   logic unused_mode;
   assign unused_mode = s0_mode;
`endif

   // S2 unpack: a negative low product borrows one from the upper field
   always_comb begin
      lo_d = p_q[PROD_W-1:0];
      hi_d = p_q[PACK_SHIFT+PROD_W-1:PACK_SHIFT] + PROD_W'(p_q[PROD_W-1]);
`ifdef MAC_INT4_EN
      if (mode_q) begin
         lo_d = i4_0_q;
         hi_d = i4_1_q;
      end
`endif
   end

   // S1/S2 pipeline registers, frozen while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q  <= '0;
         lo_q <= '0;
         hi_q <= '0;
      end else if (en) begin
         p_q  <= p_d;
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end

   // guard and sign-extension bits of the packed product are never consumed
   logic unused_p_bits;
   assign unused_p_bits = ^{p_q[P_W-1:PACK_SHIFT+PROD_W], p_q[PACK_SHIFT-1:PROD_W]};

   assign s2_lo = lo_q;
   assign s2_hi = hi_q;

endmodule

// File: rtl/packed_dual_col_mac_acc.sv
// packed_dual_col_mac_acc: two-column MAC sharing one DSP multiply per beat,
// accumulating over first..last runs behind a valid/ready handshake.
// Pipeline S0 (operand regs) -> S1 (multiply) -> S2 (unpack) -> S3 (acc).
// Optional MAC_INT4_EN: mode=1 selects INT4 dual-lane products.
module packed_dual_col_mac_acc
   import packed_dual_col_mac_acc_pkg::*;
#(
   parameter int DAT_DW     = DAT_DW_DEF,
   parameter int WT_DW      = WT_DW_DEF,
   parameter int ACC_DW     = ACC_DW_DEF,
   parameter int PACK_SHIFT = PACK_SHIFT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic              in_first,
   input  logic              in_last,
   input  logic [DAT_DW-1:0] dat,
   input  logic [WT_DW-1:0]  wt0,
   input  logic [WT_DW-1:0]  wt1,
   input  logic              mode,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [ACC_DW-1:0] acc0,
   output logic [ACC_DW-1:0] acc1
);

   localparam int STAGES = 3;   // S0..S2 carry a valid bit; S3 is the accumulator

   logic en;

   logic [STAGES-1:0]     vld_pipe_d, vld_pipe_q;
   beat_tag_t [STAGES-1:0] tag_pipe_d, tag_pipe_q;
   logic [DAT_DW-1:0]     s0_dat_d, s0_dat_q;
   logic [WT_DW-1:0]      s0_wt0_d, s0_wt0_q;
   logic [WT_DW-1:0]      s0_wt1_d, s0_wt1_q;
   logic                  s0_mode;

   logic signed [PROD_W-1:0] s2_lo, s2_hi;
   logic [ACC_DW-1:0]     acc0_d, acc0_q;
   logic [ACC_DW-1:0]     acc1_d, acc1_q;
   logic                  out_vld_d, out_vld_q;

   // the whole pipe moves together; only a held result blocks it
   assign en     = !out_vld_q || out_rdy;
   assign in_rdy = en;

`ifdef MAC_INT4_EN
   logic s0_mode_d, s0_mode_q;

   // S0 lane-mode register
   always_comb begin
      s0_mode_d = s0_mode_q;
      if (en) s0_mode_d = mode;
   end

   // S0 lane-mode flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s0_mode_q <= 1'b0;
      else        s0_mode_q <= s0_mode_d;
   end

   assign s0_mode = s0_mode_q;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign s0_mode     = 1'b0;
`endif

   // S0 capture and valid/tag shift, held while stalled
   always_comb begin
      vld_pipe_d = vld_pipe_q;
      tag_pipe_d = tag_pipe_q;
      s0_dat_d   = s0_dat_q;
      s0_wt0_d   = s0_wt0_q;
      s0_wt1_d   = s0_wt1_q;
      if (en) begin
         vld_pipe_d          = {vld_pipe_q[STAGES-2:0], in_vld};
         tag_pipe_d[STAGES-1:1] = tag_pipe_q[STAGES-2:0];
         tag_pipe_d[0].first = in_first;
         tag_pipe_d[0].last  = in_last;
         s0_dat_d            = dat;
         s0_wt0_d            = wt0;
         s0_wt1_d            = wt1;
      end
   end

   // S0 registers and stage valid/tag shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         tag_pipe_q <= '0;
         s0_dat_q   <= '0;
         s0_wt0_q   <= '0;
         s0_wt1_q   <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         tag_pipe_q <= tag_pipe_d;
         s0_dat_q   <= s0_dat_d;
         s0_wt0_q   <= s0_wt0_d;
         s0_wt1_q   <= s0_wt1_d;
      end
   end

   packed_dsp_mul #(
      .DAT_DW     (DAT_DW),
      .WT_DW      (WT_DW),
      .PACK_SHIFT (PACK_SHIFT)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .s0_dat  (s0_dat_q),
      .s0_wt0  (s0_wt0_q),
      .s0_wt1  (s0_wt1_q),
      .s0_mode (s0_mode),
      .s2_lo   (s2_lo),
      .s2_hi   (s2_hi)
   );

   // S3 accumulate; a result is flagged when a last beat lands here
   always_comb begin
      acc0_d    = acc0_q;
      acc1_d    = acc1_q;
      out_vld_d = out_vld_q;
      if (en) begin
         // en implies either nothing held or the held result is leaving now
         out_vld_d = vld_pipe_q[STAGES-1] && tag_pipe_q[STAGES-1].last;
         if (vld_pipe_q[STAGES-1]) begin
            if (tag_pipe_q[STAGES-1].first) begin
               acc0_d = {{(ACC_DW-PROD_W){s2_lo[PROD_W-1]}}, s2_lo};
               acc1_d = {{(ACC_DW-PROD_W){s2_hi[PROD_W-1]}}, s2_hi};
            end else begin
               acc0_d = acc0_q + {{(ACC_DW-PROD_W){s2_lo[PROD_W-1]}}, s2_lo};
               acc1_d = acc1_q + {{(ACC_DW-PROD_W){s2_hi[PROD_W-1]}}, s2_hi};
            end
         end
      end
   end

   // accumulator and result-valid flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc0_q    <= '0;
         acc1_q    <= '0;
         out_vld_q <= 1'b0;
      end else begin
         acc0_q    <= acc0_d;
         acc1_q    <= acc1_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign out_vld = out_vld_q;
   assign acc0    = acc0_q;
   assign acc1    = acc1_q;

endmodule
